// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one word access per memory instruction on a req/ack bus,
// stalling the pipeline until the access completes, times out or is skipped as misaligned.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] writeData_in,
    input  logic [1:0]  memToReg_in,
    input  logic [3:0]  registerFileWrite_in,
    input  logic        regWrite_in,
    input  logic [31:0] pcpp_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] DataOutDataMemory,
    output logic [1:0]  memToReg,
    output logic [31:0] ALUResult,
    output logic [3:0]  registerFileWrite,
    output logic        regWrite,
    output logic [31:0] pcpp,
    output logic        misaligned,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic             pending;
    logic             timeout_hit;
    logic             stall_fsm;

    assign misaligned  = (memRead_in | memWrite_in) & (ALUResult_in[1:0] != 2'b00);
    assign pending     = (memRead_in | memWrite_in) & ~misaligned;
    assign timeout_hit = (count == CNT_W'(TIMEOUT - 1));

    assign memToReg          = memToReg_in;
    assign ALUResult         = ALUResult_in;
    assign registerFileWrite = registerFileWrite_in;
    assign pcpp              = pcpp_in;

    // Both are forced low while reset is held so the pipeline neither stalls nor writes back.
    assign stall    = reset & stall_fsm;
    assign regWrite = reset & regWrite_in & ~(misaligned | bus_error);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_fsm = 1'b0;
        case (state)
            IDLE: begin
                stall_fsm = pending;
                if (pending) state_nxt = BUSY;
            end
            BUSY: begin
                stall_fsm = 1'b1;
                if (dmem_ack || timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dmem_req          <= 1'b0;
            dmem_we           <= 1'b0;
            dmem_addr         <= '0;
            dmem_wdata        <= '0;
            DataOutDataMemory <= '0;
            count             <= '0;
            bus_error         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= memWrite_in;
                        dmem_addr  <= ALUResult_in;
                        dmem_wdata <= writeData_in;
                        count      <= '0;
                    end
                end
                BUSY: begin
                    // An ack arriving on the timeout cycle still completes the access normally.
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) DataOutDataMemory <= dmem_rdata;
                    end else if (timeout_hit) begin
                        dmem_req  <= 1'b0;
                        bus_error <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    bus_error <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: each instruction is checked against a
// transaction-level expectation of stall/request cycle counts and DONE-cycle results.
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clock;
    logic        reset;
    logic        memRead_in;
    logic        memWrite_in;
    logic [31:0] ALUResult_in;
    logic [31:0] writeData_in;
    logic [1:0]  memToReg_in;
    logic [3:0]  registerFileWrite_in;
    logic        regWrite_in;
    logic [31:0] pcpp_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] DataOutDataMemory;
    logic [1:0]  memToReg;
    logic [31:0] ALUResult;
    logic [3:0]  registerFileWrite;
    logic        regWrite;
    logic [31:0] pcpp;
    logic        misaligned;
    logic        bus_error;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] model_data = '0;

    mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clock                (clock),
        .reset                (reset),
        .memRead_in           (memRead_in),
        .memWrite_in          (memWrite_in),
        .ALUResult_in         (ALUResult_in),
        .writeData_in         (writeData_in),
        .memToReg_in          (memToReg_in),
        .registerFileWrite_in (registerFileWrite_in),
        .regWrite_in          (regWrite_in),
        .pcpp_in              (pcpp_in),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_ack             (dmem_ack),
        .dmem_rdata           (dmem_rdata),
        .stall                (stall),
        .DataOutDataMemory    (DataOutDataMemory),
        .memToReg             (memToReg),
        .ALUResult            (ALUResult),
        .registerFileWrite    (registerFileWrite),
        .regWrite             (regWrite),
        .pcpp                 (pcpp),
        .misaligned           (misaligned),
        .bus_error            (bus_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        memRead_in           = 1'b0;
        memWrite_in          = 1'b0;
        ALUResult_in         = '0;
        writeData_in         = '0;
        memToReg_in          = '0;
        registerFileWrite_in = '0;
        regWrite_in          = 1'b0;
        pcpp_in              = '0;
    endtask

    // d = number of BUSY cycles before the one carrying ack; d >= TIMEOUT means no ack.
    task automatic run_mem(input bit is_store, input bit also_read, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int unsigned d, input bit regw);
        int unsigned busy_seen = 0;
        int unsigned stall_cnt = 0;
        int unsigned req_cnt   = 0;
        bit          done_seen = 1'b0;
        bit          timed_out;
        int unsigned exp_busy;
        logic [31:0] pc;
        timed_out = (d >= TIMEOUT);
        exp_busy  = timed_out ? TIMEOUT : d + 1;
        pc        = $urandom();
        @(negedge clock);
        memRead_in           = !is_store || also_read;
        memWrite_in          = is_store;
        ALUResult_in         = addr;
        writeData_in         = wdata;
        memToReg_in          = 2'($urandom_range(0, 3));
        registerFileWrite_in = 4'($urandom_range(0, 15));
        regWrite_in          = regw;
        pcpp_in              = pc;
        dmem_rdata           = rdata;
        for (int cyc = 0; cyc < TIMEOUT + 8; cyc++) begin
            #1;
            if (!stall) begin
                done_seen = 1'b1;
                break;
            end
            stall_cnt++;
            if (dmem_req) begin
                if (req_cnt == 0) begin
                    check("req_addr", dmem_addr, addr);
                    check("req_we", dmem_we, is_store);
                    if (is_store) check("req_wdata", dmem_wdata, wdata);
                end
                req_cnt++;
                dmem_ack = (busy_seen == d);
                busy_seen++;
            end else begin
                dmem_ack = 1'($urandom_range(0, 1));
            end
            @(negedge clock);
        end
        check("done_seen", done_seen, 1);
        check("stall_cycles", stall_cnt, exp_busy + 1);
        check("req_cycles", req_cnt, exp_busy);
        if (done_seen) begin
            if (!is_store && !timed_out) model_data = rdata;
            check("done_req", dmem_req, 0);
            check("done_bus_error", bus_error, timed_out);
            check("done_regwrite", regWrite, regw && !timed_out);
            check("done_data", DataOutDataMemory, model_data);
            check("done_aluresult", ALUResult, addr);
            check("done_pcpp", pcpp, pc);
        end
        dmem_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic run_nobus(input bit mis, input logic [31:0] addr, input bit regw);
        bit mr;
        bit mw;
        mr = 1'($urandom_range(0, 1));
        mw = mr ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clock);
        memRead_in   = mis && mr;
        memWrite_in  = mis && mw;
        ALUResult_in = addr;
        writeData_in = $urandom();
        regWrite_in  = regw;
        pcpp_in      = $urandom();
        dmem_ack     = 1'($urandom_range(0, 1));
        #1;
        check("nb_stall", stall, 0);
        check("nb_req", dmem_req, 0);
        check("nb_misaligned", misaligned, mis);
        check("nb_regwrite", regWrite, regw && !mis);
        check("nb_aluresult", ALUResult, addr);
        check("nb_data", DataOutDataMemory, model_data);
        @(negedge clock);
        #1;
        check("nb_req_after", dmem_req, 0);
        check("nb_stall_after", stall, 0);
        check("nb_data_after", DataOutDataMemory, model_data);
    endtask

    task automatic run_reset_mid_busy();
        @(negedge clock);
        memRead_in   = 1'b1;
        memWrite_in  = 1'b0;
        ALUResult_in = 32'h0000_0100;
        regWrite_in  = 1'b1;
        dmem_ack     = 1'b0;
        @(negedge clock);
        #1;
        check("rst_req_before", dmem_req, 1);
        reset = 1'b0;
        #1;
        model_data = '0;
        check("rst_req", dmem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_regwrite", regWrite, 0);
        check("rst_data", DataOutDataMemory, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_bus_error", bus_error, 0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        @(negedge clock);
        drive_idle();
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("rst_after_req", dmem_req, 0);
        check("rst_after_data", DataOutDataMemory, 0);
        check("rst_after_stall", stall, 0);
        dmem_ack = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        drive_idle();
        regWrite_in = 1'b1;
        @(negedge clock);
        #1;
        check("reset_req", dmem_req, 0);
        check("reset_we", dmem_we, 0);
        check("reset_addr", dmem_addr, 0);
        check("reset_wdata", dmem_wdata, 0);
        check("reset_data", DataOutDataMemory, 0);
        check("reset_stall", stall, 0);
        check("reset_regwrite", regWrite, 0);
        check("reset_bus_error", bus_error, 0);
        @(negedge clock);
        reset = 1'b1;

        run_mem(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1, 1'b1);
        run_mem(1'b1, 1'b0, 32'h0000_0080, 32'h1234_5678, 32'h5555_AAAA, 0, 1'b0);
        run_mem(1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'h0BAD_0BAD, 100, 1'b1);
        run_nobus(1'b1, 32'h0000_0042, 1'b1);
        run_reset_mid_busy();
        run_nobus(1'b0, 32'h0000_0007, 1'b1);
        run_mem(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h1111_2222, TIMEOUT - 1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            int unsigned kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a    = $urandom() & 32'hFFFF_FFFC;
            case (kind)
                0: run_mem(1'b0, 1'b0, a, $urandom(), $urandom(), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
                1: run_mem(1'b1, 1'($urandom_range(0, 1)), a, $urandom(), $urandom(), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
                2: run_nobus(1'b0, $urandom(), 1'($urandom_range(0, 1)));
                default: run_nobus(1'b1, a | 32'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
